uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter CLKS_PER_BIT, default 5208, clock cycles per serial bit (50 MHz / 9600 baud); minimum 4.
REQ-002 Parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-003 Parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-004 Parameter STOP_BITS, default 1, stop bits per frame; legal values 1 or 2.
REQ-005 Parameter FIFO_DEPTH, default 16, receive FIFO entries; power of 2, minimum 2.
REQ-006 Clk  in  1  single clock; all state updates on its rising edge.
REQ-007 Reset_n  in  1  synchronous active-low reset.
REQ-008 serial_in  in  1  asynchronous UART line, idle high.
REQ-009 rx_ready  in  1  consumer accepts the head word this cycle.
REQ-010 err_clear  in  1  clears all sticky error flags.
REQ-011 rx_data  out  DATA_BITS  FIFO head word; valid only when rx_valid=1.
REQ-012 rx_valid  out  1  FIFO not empty.
REQ-013 fifo_count  out  $clog2(FIFO_DEPTH)+1  number of stored words.
REQ-014 busy  out  1  receiver FSM is not IDLE.
REQ-015 overflow, parity_err, framing_err  out  1 each  sticky error flags.

Function
REQ-016 serial_in passes through a 2-flop synchroniser; both flops reset to 1; all sampling uses the synchronised value.
REQ-017 FSM states: IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY=0.
REQ-018 IDLE -> START on a synchronised 1->0 transition; the bit counter clears to 0.
REQ-019 START samples the line at count CLKS_PER_BIT/2 (integer division); sample=1 -> IDLE with no flag set (glitch reject); sample=0 -> DATA with the counter cleared.
REQ-020 DATA samples every CLKS_PER_BIT cycles, DATA_BITS times, LSB first, into a shift register.
REQ-021 PARITY samples one bit after CLKS_PER_BIT cycles; the frame is bad if XOR(data, parity bit) is not 1 for odd mode or not 0 for even mode.
REQ-022 STOP samples STOP_BITS bits at CLKS_PER_BIT spacing; any sampled 0 marks a framing error.
REQ-023 After the last stop sample the FSM returns to IDLE in the next cycle; IDLE detects a new start only after the line is seen high.
REQ-024 On a good frame, the word is pushed in the cycle after the last stop sample; rx_valid rises in the following cycle if the FIFO was empty.
REQ-025 A frame with a parity error sets parity_err and is not pushed; a frame with a framing error sets framing_err and is not pushed; if both occur, both flags set.
REQ-026 A good frame arriving while fifo_count=FIFO_DEPTH and no pop occurs in that cycle sets overflow and is dropped; the FIFO contents are unchanged.
REQ-027 The FIFO is first-word-fall-through: rx_valid = (fifo_count != 0), rx_data = oldest word, and a pop occurs when rx_valid && rx_ready.
REQ-028 rx_ready while empty has no effect; fifo_count never underflows.
REQ-029 Push and pop in the same cycle leave fifo_count unchanged; this holds when full, so no overflow occurs.
REQ-030 Read and write pointers wrap modulo FIFO_DEPTH.
REQ-031 err_clear=1 clears all three sticky flags; a flag-setting event in the same cycle takes priority and leaves that flag set.

Reset
REQ-032 Reset_n=0 at a clock edge forces: FSM to IDLE; counters and shift register to 0; FIFO empty (pointers 0); rx_valid=0, fifo_count=0, busy=0; overflow, parity_err, framing_err = 0; rx_data=0.
REQ-033 Reset asserted mid-frame aborts the frame with no push and no flag set; reception resumes at the next falling edge after Reset_n=1.

Verification (bench parameters: CLKS_PER_BIT=8, FIFO_DEPTH=4, 8N1 unless stated)
REQ-034 Send 0x24 ('$') with rx_ready=0 -> rx_valid=1, rx_data=0x24, fifo_count=1, no error flags set.
REQ-035 Send "$GPGLL" with rx_ready=0 -> fifo_count=4 and overflow=1 after the 5th byte; pulsing rx_ready then yields 0x24, 0x47, 0x50, 0x47 and rx_valid=0.
REQ-036 PARITY=2, send 0x41 with parity bit 1 -> parity_err=1, fifo_count=0; err_clear pulse -> parity_err=0.
REQ-037 Send 0x55 with stop bit 0 -> framing_err=1, no push; the next frame 0x2C is received correctly.
REQ-038 A low glitch of 3 clocks on an idle line -> busy returns to 0, no push, no flags set.
REQ-039 Reset_n=0 during data bit 4 of a frame, with 2 words queued -> fifo_count=0, busy=0, all flags 0; the next frame 0x4E is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receiver (2-flop synchronised line, mid-bit sampling) feeding a
// first-word-fall-through receive FIFO with sticky error flags.
module uart_rx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          serial_in,
  input  logic                          rx_ready,
  input  logic                          err_clear,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          overflow,
  output logic                          parity_err,
  output logic                          framing_err
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(CLKS_PER_BIT) + 1;
  localparam int unsigned BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY_BIT, STOP} state_t;

  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [BW-1:0]        bit_idx, bit_n;
  logic [DATA_BITS-1:0] shreg, sh_n;
  logic                 perr, perr_n, ferr, ferr_n, done, done_n;
  logic                 sync1, line, line_prev;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          count_n;
  logic                 push_c, pop_c, wr_en_c;

  // Line synchroniser and previous-sample register for start-edge detection
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1     <= 1'b1;
      line      <= 1'b1;
      line_prev <= 1'b1;
    end else begin
      sync1     <= serial_in;
      line      <= sync1;
      line_prev <= line;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      shreg   <= sh_n;
      perr    <= perr_n;
      ferr    <= ferr_n;
      done    <= done_n;
      busy    <= (state_n != IDLE);
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt + CW'(1);
    bit_n   = bit_idx;
    sh_n    = shreg;
    perr_n  = perr;
    ferr_n  = ferr;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (line_prev && !line) begin
          state_n = START;
          bit_n   = '0;
          perr_n  = 1'b0;
          ferr_n  = 1'b0;
        end
      end
      START: begin
        if (cnt == HALF) begin
          cnt_n   = '0;
          bit_n   = '0;
          state_n = line ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == LAST) begin
          cnt_n = '0;
          sh_n  = {line, shreg[DATA_BITS-1:1]};
          if (bit_idx == BW'(DATA_BITS - 1)) begin
            bit_n   = '0;
            state_n = (PARITY != 0) ? PARITY_BIT : STOP;
          end else begin
            bit_n = bit_idx + BW'(1);
          end
        end
      end
      PARITY_BIT: begin
        if (cnt == LAST) begin
          cnt_n   = '0;
          perr_n  = ((^{shreg, line}) != (PARITY == 1));
          bit_n   = '0;
          state_n = STOP;
        end
      end
      STOP: begin
        if (cnt == LAST) begin
          cnt_n = '0;
          if (!line) ferr_n = 1'b1;
          if (bit_idx == BW'(STOP_BITS - 1)) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            bit_n = bit_idx + BW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // A full FIFO still accepts a word when the head is popped in the same cycle
  always_comb begin
    push_c  = done && !perr && !ferr;
    pop_c   = rx_valid && rx_ready;
    wr_en_c = push_c && ((fifo_count != FULL) || pop_c);
    count_n = fifo_count;
    if (wr_en_c && !pop_c)      count_n = fifo_count + (AW+1)'(1);
    else if (!wr_en_c && pop_c) count_n = fifo_count - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      rx_valid    <= 1'b0;
      overflow    <= 1'b0;
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      if (wr_en_c) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_c) rd_ptr <= rd_ptr + AW'(1);
      fifo_count  <= count_n;
      rx_valid    <= (count_n != '0);
      overflow    <= (push_c && !wr_en_c) || (overflow && !err_clear);
      parity_err  <= (done && perr) || (parity_err && !err_clear);
      framing_err <= (done && ferr) || (framing_err && !err_clear);
    end
  end

  assign rx_data = mem[rd_ptr];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios plus random frames checked
// against a queue-based model of the receive FIFO and its error flags.
module tb_uart_rx_fifo;
  localparam int unsigned CPB   = 8;
  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       serial_in = 1'b1;
  logic       serial_p = 1'b1;
  logic       rx_ready = 1'b0;
  logic       err_clear = 1'b0;
  logic [7:0] rx_data, p_rx_data;
  logic [2:0] fifo_count, p_fifo_count;
  logic       rx_valid, busy, overflow, parity_err, framing_err;
  logic       p_rx_valid, p_busy, p_overflow, p_parity_err, p_framing_err;

  int checks = 0;
  int passed = 0;
  byte unsigned model_q[$];
  bit m_ovf = 1'b0, m_ferr = 1'b0;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                 .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .serial_in(serial_in), .rx_ready(rx_ready),
    .err_clear(err_clear), .rx_data(rx_data), .rx_valid(rx_valid),
    .fifo_count(fifo_count), .busy(busy), .overflow(overflow),
    .parity_err(parity_err), .framing_err(framing_err));

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1),
                 .FIFO_DEPTH(DEPTH)) dut_p (
    .clk(clk), .reset_n(reset_n), .serial_in(serial_p), .rx_ready(1'b0),
    .err_clear(err_clear), .rx_data(p_rx_data), .rx_valid(p_rx_valid),
    .fifo_count(p_fifo_count), .busy(p_busy), .overflow(p_overflow),
    .parity_err(p_parity_err), .framing_err(p_framing_err));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish within 500000 ns");
    $fatal(1, "timeout");
  end

  task automatic drive_bit(input bit b, input bit to_p);
    if (to_p) serial_p = b; else serial_in = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop, input bit to_p,
                            input bit par_en, input bit par_val);
    @(negedge clk);
    drive_bit(1'b0, to_p);
    for (int i = 0; i < 8; i++) drive_bit(d[i], to_p);
    if (par_en) drive_bit(par_val, to_p);
    drive_bit(stop, to_p);
    if (to_p) serial_p = 1'b1; else serial_in = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  // Model: a good frame is queued unless the FIFO is full; a bad one only flags
  function automatic void model_frame(input byte unsigned d, input bit good);
    if (!good) m_ferr = 1'b1;
    else if (model_q.size() < DEPTH) model_q.push_back(d);
    else m_ovf = 1'b1;
  endfunction

  task automatic pulse_ready();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic pulse_clear();
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    m_ovf = 1'b0;
    m_ferr = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({rx_valid, busy, overflow, parity_err, framing_err, fifo_count, rx_data} !== 16'h0)
      $display("FAIL reset_outputs: got valid=%b busy=%b ovf=%b perr=%b ferr=%b cnt=%0d data=%h want all zero",
               rx_valid, busy, overflow, parity_err, framing_err, fifo_count, rx_data);
    else passed++;
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({rx_valid, busy, fifo_count} !== 5'h0)
      $display("FAIL reset_release: got valid=%b busy=%b cnt=%0d want 0 0 0", rx_valid, busy, fifo_count);
    else passed++;
  endtask

  task automatic test_single();
    send_frame(8'h24, 1'b1, 1'b0, 1'b0, 1'b0);
    model_frame(8'h24, 1'b1);
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h24 || fifo_count !== 3'd1)
      $display("FAIL single_word: got valid=%b data=%h cnt=%0d want 1 24 1", rx_valid, rx_data, fifo_count);
    else passed++;
    checks++;
    if ({overflow, parity_err, framing_err} !== 3'b000)
      $display("FAIL single_flags: got %b want 000", {overflow, parity_err, framing_err});
    else passed++;
  endtask

  task automatic test_overflow();
    byte unsigned msg[6] = '{8'h24, 8'h47, 8'h50, 8'h47, 8'h4C, 8'h4C};
    byte unsigned expd[4] = '{8'h24, 8'h47, 8'h50, 8'h47};
    pulse_ready();
    void'(model_q.pop_front());
    for (int i = 0; i < 5; i++) begin
      send_frame(msg[i], 1'b1, 1'b0, 1'b0, 1'b0);
      model_frame(msg[i], 1'b1);
      if (i == 3) begin
        checks++;
        if (fifo_count !== 3'd4 || overflow !== 1'b0)
          $display("FAIL fill_four: got cnt=%0d ovf=%b want 4 0", fifo_count, overflow);
        else passed++;
      end
    end
    checks++;
    if (fifo_count !== 3'd4 || overflow !== m_ovf || m_ovf !== 1'b1)
      $display("FAIL overflow_fifth: got cnt=%0d ovf=%b want 4 1", fifo_count, overflow);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rx_valid !== 1'b1 || rx_data !== expd[i] || rx_data !== model_q[0])
        $display("FAIL overflow_drain%0d: got valid=%b data=%h want 1 %h", i, rx_valid, rx_data, expd[i]);
      else passed++;
      pulse_ready();
      void'(model_q.pop_front());
    end
    @(negedge clk);
    checks++;
    if (rx_valid !== 1'b0 || fifo_count !== 3'd0)
      $display("FAIL overflow_empty: got valid=%b cnt=%0d want 0 0", rx_valid, fifo_count);
    else passed++;
  endtask

  task automatic test_push_pop_full();
    bit seen = 1'b0;
    pulse_clear();
    checks++;
    if (overflow !== 1'b0)
      $display("FAIL ovf_clear: got %b want 0", overflow);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      byte unsigned d = byte'($urandom);
      send_frame(d, 1'b1, 1'b0, 1'b0, 1'b0);
      model_frame(d, 1'b1);
    end
    // Pop exactly in the cycle the new word is pushed (the cycle after busy drops)
    fork
      send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
      begin
        bit was_busy = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
          @(negedge clk);
          if (busy) was_busy = 1'b1;
          else if (was_busy) begin
            seen = 1'b1;
            pulse_ready();
          end
        end
      end
    join
    void'(model_q.pop_front());
    model_q.push_back(8'h5A);
    checks++;
    if (!seen) $display("FAIL pushpop_wait: busy never fell, got seen=0 want 1");
    else passed++;
    checks++;
    if (fifo_count !== 3'd4 || overflow !== 1'b0 || rx_data !== model_q[0])
      $display("FAIL pushpop_full: got cnt=%0d ovf=%b head=%h want 4 0 %h", fifo_count, overflow, rx_data, model_q[0]);
    else passed++;
    while (model_q.size() > 0) begin
      checks++;
      if (rx_data !== model_q[0])
        $display("FAIL pushpop_drain: got %h want %h", rx_data, model_q[0]);
      else passed++;
      pulse_ready();
      void'(model_q.pop_front());
    end
  endtask

  task automatic test_parity();
    send_frame(8'h41, 1'b1, 1'b1, 1'b1, 1'b1);
    checks++;
    if (p_parity_err !== 1'b1 || p_fifo_count !== 3'd0 || p_framing_err !== 1'b0)
      $display("FAIL parity_bad: got perr=%b cnt=%0d ferr=%b want 1 0 0", p_parity_err, p_fifo_count, p_framing_err);
    else passed++;
    pulse_clear();
    checks++;
    if (p_parity_err !== 1'b0)
      $display("FAIL parity_clear: got %b want 0", p_parity_err);
    else passed++;
    send_frame(8'h41, 1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if (p_parity_err !== 1'b0 || p_fifo_count !== 3'd1 || p_rx_data !== 8'h41)
      $display("FAIL parity_good: got perr=%b cnt=%0d data=%h want 0 1 41", p_parity_err, p_fifo_count, p_rx_data);
    else passed++;
  endtask

  task automatic test_framing();
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    model_frame(8'h55, 1'b0);
    checks++;
    if (framing_err !== 1'b1 || fifo_count !== 3'd0 || parity_err !== 1'b0)
      $display("FAIL framing_bad: got ferr=%b cnt=%0d perr=%b want 1 0 0", framing_err, fifo_count, parity_err);
    else passed++;
    send_frame(8'h2C, 1'b1, 1'b0, 1'b0, 1'b0);
    model_frame(8'h2C, 1'b1);
    checks++;
    if (fifo_count !== 3'd1 || rx_data !== 8'h2C || rx_valid !== 1'b1)
      $display("FAIL framing_next: got cnt=%0d data=%h valid=%b want 1 2c 1", fifo_count, rx_data, rx_valid);
    else passed++;
    pulse_ready();
    void'(model_q.pop_front());
    pulse_clear();
  endtask

  task automatic test_glitch();
    bit went_busy = 1'b0;
    @(negedge clk);
    serial_in = 1'b0;
    repeat (3) @(negedge clk);
    serial_in = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (busy) went_busy = 1'b1;
      @(negedge clk);
    end
    repeat (12) @(negedge clk);
    checks++;
    if (!went_busy) $display("FAIL glitch_start: got busy never 1 want 1");
    else passed++;
    checks++;
    if ({busy, fifo_count, overflow, parity_err, framing_err} !== 7'h0)
      $display("FAIL glitch_reject: got busy=%b cnt=%0d flags=%b want 0 0 000",
               busy, fifo_count, {overflow, parity_err, framing_err});
    else passed++;
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d = 8'hA5;
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h31, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'h32, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (fifo_count !== 3'd2 || framing_err !== 1'b1)
      $display("FAIL premid_state: got cnt=%0d ferr=%b want 2 1", fifo_count, framing_err);
    else passed++;
    @(negedge clk);
    serial_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      serial_in = d[i];
      repeat (CPB) @(negedge clk);
    end
    serial_in = d[4];
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b1) $display("FAIL midframe_busy: got %b want 1", busy);
    else passed++;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    serial_in = 1'b1;
    model_q.delete();
    m_ovf = 1'b0;
    m_ferr = 1'b0;
    repeat (30) @(negedge clk);
    checks++;
    if ({busy, rx_valid, fifo_count, overflow, parity_err, framing_err} !== 8'h0)
      $display("FAIL midframe_reset: got busy=%b valid=%b cnt=%0d flags=%b want all 0",
               busy, rx_valid, fifo_count, {overflow, parity_err, framing_err});
    else passed++;
    send_frame(8'h4E, 1'b1, 1'b0, 1'b0, 1'b0);
    model_frame(8'h4E, 1'b1);
    checks++;
    if (fifo_count !== 3'd1 || rx_data !== 8'h4E || framing_err !== 1'b0)
      $display("FAIL post_reset_rx: got cnt=%0d data=%h ferr=%b want 1 4e 0", fifo_count, rx_data, framing_err);
    else passed++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 24; it++) begin
      byte unsigned d = byte'($urandom);
      bit good = ($urandom_range(0, 4) != 0);
      int npop = $urandom_range(0, 2);
      send_frame(d, good, 1'b0, 1'b0, 1'b0);
      model_frame(d, good);
      checks++;
      if (fifo_count !== 3'(model_q.size()) || rx_valid !== (model_q.size() != 0) ||
          overflow !== m_ovf || framing_err !== m_ferr || parity_err !== 1'b0)
        $display("FAIL rand_state%0d: got cnt=%0d valid=%b ovf=%b ferr=%b perr=%b want %0d %b %b %b 0",
                 it, fifo_count, rx_valid, overflow, framing_err, parity_err,
                 model_q.size(), model_q.size() != 0, m_ovf, m_ferr);
      else passed++;
      for (int p = 0; p < npop; p++) begin
        if (model_q.size() > 0) begin
          checks++;
          if (rx_data !== model_q[0])
            $display("FAIL rand_head%0d: got %h want %h", it, rx_data, model_q[0]);
          else passed++;
          void'(model_q.pop_front());
        end
        pulse_ready();
      end
      @(negedge clk);
      checks++;
      if (fifo_count !== 3'(model_q.size()))
        $display("FAIL rand_popcnt%0d: got %0d want %0d", it, fifo_count, model_q.size());
      else passed++;
      if ($urandom_range(0, 5) == 0) pulse_clear();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_push_pop_full();
    test_parity();
    test_framing();
    test_glitch();
    test_reset_mid_frame();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
